branch_predictor: RTL and testbench
===================================

# branch_predictor

Gshare branch direction predictor with a direct-mapped branch target buffer (BTB), sitting directly upstream of the fetch stage. Each cycle it looks up the current fetch PC combinationally and drives `guess_branch`, `branch_target` and `branch_history` into fetch. It keeps a speculative global history register (GHR) and trains its counters and BTB from branches resolved in execute. On a misprediction it restores the GHR from the history snapshot carried down the pipeline.

## Interface
Parameters:
- `HIST_W`, 5: GHR width; also the index width. The table holds 2^HIST_W counters and 2^HIST_W BTB entries.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `fetch_pc`  in  32  current PC register output of fetch.
- `pc_load`  in  1  fetch PC register loads this cycle; the current lookup is consumed.
- `exe_br_valid`  in  1  a conditional branch resolves in execute this cycle.
- `exe_pc`  in  32  PC of the resolving branch.
- `exe_taken`  in  1  actual direction of the resolving branch.
- `exe_target`  in  32  actual taken target of the resolving branch.
- `exe_history`  in  HIST_W  GHR snapshot that travelled with the branch.
- `misprediction`  in  1  execute flags the guess as wrong; fetch redirects.
- `guess_branch`  out  1  predicted taken with BTB hit.
- `branch_target`  out  32  BTB target for `fetch_pc`.
- `branch_history`  out  HIST_W  GHR value used for this lookup.

## Operation
- Index: `idx = fetch_pc[HIST_W+1:2] ^ ghr`. BTB index: `bidx = fetch_pc[HIST_W+1:2]`. BTB tag: `fetch_pc[31:HIST_W+2]`.
- Storage:
  - PHT: 2^HIST_W two-bit saturating counters.
  - BTB: valid bit, tag and 32-bit target per entry.
- BTB hit: `valid[bidx] && tag[bidx] == fetch_pc[31:HIST_W+2]`.
- Outputs:
  - `guess_branch = hit && pht[idx][1]`.
  - `branch_target = target[bidx]`, driven regardless of hit.
  - `branch_history = ghr`.
- GHR, priority order:
  1. `misprediction`: `ghr <= {exe_history[HIST_W-2:0], exe_taken}`. This beats `pc_load`.
  2. else `pc_load && hit`: `ghr <= {ghr[HIST_W-2:0], guess_branch}`.
  3. else GHR holds. Non-hit PCs do not shift history.
- Training, when `exe_br_valid`:
  - Counter at `exe_pc[HIST_W+1:2] ^ exe_history`:
    - taken: +1, saturating at 3.
    - not taken: -1, saturating at 0.
  - If `exe_taken`, write BTB entry `exe_pc[HIST_W+1:2]`: valid=1, tag, target=`exe_target`.
  - Not-taken branches leave the BTB unchanged.
- `misprediction` without `exe_br_valid` (for example a jump) restores the GHR only. The PHT and BTB are not modified.
- Counter encoding: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.

## Timing
- Lookup is purely combinational, from `fetch_pc`/GHR to the outputs within the same cycle, with no latency. Fetch consumes it the same cycle.
- All PHT, BTB and GHR writes take effect at the rising edge. A lookup in the same cycle as a write to the same entry sees the old value; the next cycle sees the new one.
- Reset, asynchronous, while `rst` is high:
  - GHR=0, all counters=1, all valid=0, all targets=0, all tags=0.
  - Outputs during and right after reset: `guess_branch`=0, `branch_target`=0, `branch_history`=0.
- Reset asserted mid-operation clears all state immediately, with no wait for a clock edge. Pending updates in that cycle are dropped.
- When `misprediction` and `pc_load && hit` occur in the same cycle, the restore wins and the speculative shift is discarded.
- When `exe_br_valid` and a lookup hit the same PHT index in the same cycle, the update lands and the lookup uses the pre-update counter.
- Counter saturation: 3 plus taken stays 3; 0 plus not-taken stays 0. There is no wrap.
- Index arithmetic is modulo 2^HIST_W through the XOR only; there is no addition.

## Test plan
- Reset: assert `rst` with no clock edge → all outputs 0 immediately. After release, `fetch_pc`=0x100 → `guess_branch`=0 and `branch_history`=0.
- Train and hit:
  - Resolve `exe_pc`=0x40, taken, `exe_target`=0x80, `exe_history`=0. Counter idx 0x10 goes 1→2 and the BTB is written.
  - Next cycle, `fetch_pc`=0x40 with ghr=0 → `guess_branch`=1, `branch_target`=0x80.
- Saturation: 4 taken resolutions on one index → counter 3. One not-taken → 2, so the prediction is still taken. Two more not-taken → 0. A further not-taken stays 0.
- Speculative history: three `pc_load` cycles on BTB hits predicted T, T, NT from ghr=0 → `branch_history` goes 0, 1, 3, 6.
- Misprediction priority: ghr=0x06, `misprediction`=1 with `exe_history`=0x1F and `exe_taken`=0, plus `pc_load` with a hit in the same cycle → ghr becomes 0x1E.
- Same-cycle collision: a lookup and a training update hit the same index whose counter is 1, with taken → that cycle `guess_branch`=0; next cycle `guess_branch`=1.

Source files
------------

// File: rtl/branch_predictor.sv
// Gshare direction predictor with a direct-mapped BTB.
// Lookup is combinational on fetch_pc and the speculative GHR. Training
// comes from branches resolved in execute. A misprediction restores the GHR
// from the snapshot carried down the pipeline.
module branch_predictor #(
  parameter int HIST_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       fetch_pc,
  input  logic              pc_load,
  input  logic              exe_br_valid,
  input  logic [31:0]       exe_pc,
  input  logic              exe_taken,
  input  logic [31:0]       exe_target,
  input  logic [HIST_W-1:0] exe_history,
  input  logic              misprediction,
  output logic              guess_branch,
  output logic [31:0]       branch_target,
  output logic [HIST_W-1:0] branch_history
);

  localparam int ENTRIES = 1 << HIST_W;
  localparam int TAG_W   = 30 - HIST_W;

  logic [1:0]        r_pht    [ENTRIES];
  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [31:0]       r_target [ENTRIES];
  logic [HIST_W-1:0] r_ghr;

  logic [HIST_W-1:0] w_bidx;
  logic [HIST_W-1:0] w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic [HIST_W-1:0] w_ebidx;
  logic [HIST_W-1:0] w_eidx;
  logic [TAG_W-1:0]  w_etag;
  logic [1:0]        w_ecnt;
  logic              w_unused;

  // Word-aligned PCs: the two low bits never take part in indexing.
  assign w_unused = ^{fetch_pc[1:0], exe_pc[1:0]};

  // Lookup side: BTB indexed by PC alone, PHT by PC xor history.
  assign w_bidx = fetch_pc[HIST_W+1:2];
  assign w_idx  = w_bidx ^ r_ghr;
  assign w_tag  = fetch_pc[31:HIST_W+2];
  assign w_hit  = r_valid[w_bidx] && (r_tag[w_bidx] == w_tag);

  assign guess_branch   = w_hit && r_pht[w_idx][1];
  assign branch_target  = r_target[w_bidx];
  assign branch_history = r_ghr;

  // Training side uses the history the branch was predicted with.
  assign w_ebidx = exe_pc[HIST_W+1:2];
  assign w_eidx  = w_ebidx ^ exe_history;
  assign w_etag  = exe_pc[31:HIST_W+2];
  assign w_ecnt  = r_pht[w_eidx];

  // Speculative GHR: restore on mispredict beats the shift on a consumed hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_ghr <= '0;
    else if (misprediction)
      r_ghr <= {exe_history[HIST_W-2:0], exe_taken};
    else if (pc_load && w_hit)
      r_ghr <= {r_ghr[HIST_W-2:0], guess_branch};
  end

  // Two-bit saturating counters, trained on every resolved branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_pht[i] <= 2'd1;
    end else if (exe_br_valid) begin
      if (exe_taken && w_ecnt != 2'd3)
        r_pht[w_eidx] <= w_ecnt + 2'd1;
      else if (!exe_taken && w_ecnt != 2'd0)
        r_pht[w_eidx] <= w_ecnt - 2'd1;
    end
  end

  // BTB allocation only on taken branches; not-taken leaves the entry alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
      end
    end else if (exe_br_valid && exe_taken) begin
      r_valid[w_ebidx]  <= 1'b1;
      r_tag[w_ebidx]    <= w_etag;
      r_target[w_ebidx] <= exe_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expected lookups are queued as each
// step is driven and drained against the combinational outputs.
module tb_branch_predictor;

  localparam int HIST_W = 5;

  logic              clk;
  logic              rst;
  logic [31:0]       fetch_pc;
  logic              pc_load;
  logic              exe_br_valid;
  logic [31:0]       exe_pc;
  logic              exe_taken;
  logic [31:0]       exe_target;
  logic [HIST_W-1:0] exe_history;
  logic              misprediction;
  logic              guess_branch;
  logic [31:0]       branch_target;
  logic [HIST_W-1:0] branch_history;

  typedef struct packed {
    logic              g;
    logic [31:0]       t;
    logic [HIST_W-1:0] h;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  branch_predictor #(.HIST_W(HIST_W)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pc_load(pc_load),
    .exe_br_valid(exe_br_valid), .exe_pc(exe_pc), .exe_taken(exe_taken),
    .exe_target(exe_target), .exe_history(exe_history),
    .misprediction(misprediction), .guess_branch(guess_branch),
    .branch_target(branch_target), .branch_history(branch_history)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drain every queued expectation against the settled outputs.
  task automatic drain();
    exp_t  e;
    string s;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = tag_q.pop_front();
      checks++;
      assert (guess_branch === e.g) else begin
        errors++;
        $error("FAIL %s guess_branch observed=%0h expected=%0h", s, guess_branch, e.g);
      end
      checks++;
      assert (branch_target === e.t) else begin
        errors++;
        $error("FAIL %s branch_target observed=%0h expected=%0h", s, branch_target, e.t);
      end
      checks++;
      assert (branch_history === e.h) else begin
        errors++;
        $error("FAIL %s branch_history observed=%0h expected=%0h", s, branch_history, e.h);
      end
    end
  endtask

  task automatic expect_now(input string s, input logic g, input logic [31:0] t,
                            input logic [HIST_W-1:0] h);
    exp_t e;
    e.g = g; e.t = t; e.h = h;
    exp_q.push_back(e);
    tag_q.push_back(s);
    #1;
    drain();
  endtask

  task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic [HIST_W-1:0] hist);
    exe_br_valid = 1'b1; exe_pc = pc; exe_taken = tk;
    exe_target = tgt; exe_history = hist;
    tick();
    exe_br_valid = 1'b0;
  endtask

  // One resolution of the branch at 0x40 (PHT idx 0x10 with history 0),
  // then look it up with ghr=0 and check the direction.
  task automatic sat_step(input string s, input logic tk, input logic g);
    fetch_pc = 32'h40; pc_load = 1'b0;
    train(32'h40, tk, 32'h80, 5'h00);
    expect_now(s, g, 32'h80, 5'h00);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; fetch_pc = 32'h100; pc_load = 1'b0; exe_br_valid = 1'b0;
    exe_pc = '0; exe_taken = 1'b0; exe_target = '0; exe_history = '0;
    misprediction = 1'b0;

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    expect_now("reset_async", 1'b0, 32'h0, 5'h00);
    @(negedge clk);
    rst = 1'b0;
    tick();
    expect_now("post_reset", 1'b0, 32'h0, 5'h00);

    // Train 0x40 taken -> 0x80; same-cycle lookup still sees the empty BTB.
    fetch_pc = 32'h40;
    exe_br_valid = 1'b1; exe_pc = 32'h40; exe_taken = 1'b1;
    exe_target = 32'h80; exe_history = 5'h00;
    expect_now("train_same_cycle", 1'b0, 32'h0, 5'h00);
    tick();
    exe_br_valid = 1'b0;
    expect_now("train_hit", 1'b1, 32'h80, 5'h00);

    // Saturation on idx 0x10, counter currently 2.
    sat_step("sat_t_3",   1'b1, 1'b1);
    sat_step("sat_t_3a",  1'b1, 1'b1);
    sat_step("sat_t_3b",  1'b1, 1'b1);
    sat_step("sat_nt_2",  1'b0, 1'b1);
    sat_step("sat_nt_1",  1'b0, 1'b0);
    sat_step("sat_nt_0",  1'b0, 1'b0);
    sat_step("sat_nt_0a", 1'b0, 1'b0);
    sat_step("sat_t_1",   1'b1, 1'b0);
    sat_step("sat_t_2",   1'b1, 1'b1);

    // BTB entries for 0x44 and 0x48, counters trained away from idx 0x11.
    train(32'h44, 1'b1, 32'h200, 5'h1F);
    train(32'h48, 1'b1, 32'h300, 5'h1F);

    // Speculative history: T (idx 0x10), T (idx 0x10), NT (idx 0x11).
    pc_load = 1'b1;
    fetch_pc = 32'h40;
    expect_now("spec_h0", 1'b1, 32'h80, 5'h00);
    tick();
    fetch_pc = 32'h44;
    expect_now("spec_h1", 1'b1, 32'h200, 5'h01);
    tick();
    fetch_pc = 32'h48;
    expect_now("spec_h3", 1'b0, 32'h300, 5'h03);
    tick();
    fetch_pc = 32'h100;
    expect_now("spec_h6", 1'b0, 32'h0, 5'h06);
    tick();
    pc_load = 1'b0;
    expect_now("nonhit_hold", 1'b0, 32'h0, 5'h06);

    // Misprediction restore beats a same-cycle consumed hit.
    fetch_pc = 32'h40; pc_load = 1'b1;
    misprediction = 1'b1; exe_history = 5'h1F; exe_taken = 1'b0;
    expect_now("mp_same_cycle", 1'b0, 32'h80, 5'h06);
    tick();
    misprediction = 1'b0; pc_load = 1'b0; fetch_pc = 32'h100;
    expect_now("mp_restore_nt", 1'b0, 32'h0, 5'h1E);
    misprediction = 1'b1; exe_history = 5'h03; exe_taken = 1'b1;
    tick();
    misprediction = 1'b0;
    expect_now("mp_restore_t", 1'b0, 32'h0, 5'h07);

    // Collision: lookup and update both on idx 0x12^7 = 0x15, counter 1.
    fetch_pc = 32'h48;
    exe_br_valid = 1'b1; exe_pc = 32'h48; exe_taken = 1'b1;
    exe_target = 32'h300; exe_history = 5'h07;
    expect_now("coll_same", 1'b0, 32'h300, 5'h07);
    tick();
    exe_br_valid = 1'b0;
    expect_now("coll_next", 1'b1, 32'h300, 5'h07);

    // Mid-run reset clears state at once and drops the pending update.
    #3;
    exe_br_valid = 1'b1; exe_pc = 32'h4C; exe_taken = 1'b1;
    exe_target = 32'h999; exe_history = 5'h00;
    rst = 1'b1;
    expect_now("reset_mid", 1'b0, 32'h0, 5'h00);
    @(posedge clk);
    #2;
    rst = 1'b0; exe_br_valid = 1'b0;
    fetch_pc = 32'h4C;
    expect_now("reset_drop", 1'b0, 32'h0, 5'h00);
    fetch_pc = 32'h48;
    expect_now("reset_btb_clr", 1'b0, 32'h0, 5'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
